// File: rtl/fwd_pktbuf.sv
// fwd_pktbuf: store-and-forward packet buffer placed after the packet filter's
// AXI Stream forwarder. Only complete packets are presented at the egress;
// packets that do not fit are dropped whole, never truncated.
//
// Build option:
//   FWD_PKTBUF_DROP_CNT_EN - when defined, pkts_dropped is a saturating count of
//                            dropped packets; otherwise it is tied to zero and
//                            the counter logic is left out. Dropping itself
//                            behaves the same either way.
module fwd_pktbuf #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_WORDS = 512,
    parameter int MAX_PKTS    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_TDATA,
    input  logic [DATA_WIDTH/8-1:0]     in_TKEEP,
    input  logic                        in_TLAST,
    input  logic                        in_TVALID,
    output logic                        in_TREADY,
    output logic [DATA_WIDTH-1:0]       out_TDATA,
    output logic [DATA_WIDTH/8-1:0]     out_TKEEP,
    output logic                        out_TLAST,
    output logic                        out_TVALID,
    input  logic                        out_TREADY,
    output logic [$clog2(MAX_PKTS):0]   pkt_count,
    output logic [15:0]                 pkts_dropped
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;
    localparam int MW = DATA_WIDTH + KW + 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);
    localparam logic [CW-1:0] MAXP_P  = CW'(MAX_PKTS);

    typedef enum logic {
        ST_WR   = 1'b0,
        ST_DROP = 1'b1
    } wrState_t;

    wrState_t               wrState_q;
    logic [PW-1:0]          wrPtr_q;
    logic [PW-1:0]          wrCommit_q;
    logic [PW-1:0]          rdPtr_q;
    logic [CW-1:0]          pktCount_q;
    logic [CW-1:0]          pktCount_d;
    logic                   inReady_q;
    logic                   outValid_q;
    logic                   outLast_q;
    logic [DATA_WIDTH-1:0]  outData_q;
    logic [KW-1:0]          outKeep_q;

    logic [MW-1:0]          mem [DEPTH_WORDS];
    logic [MW-1:0]          rdWord;

    logic                   beatIn;
    logic [PW-1:0]          usedWords;
    logic                   bufFull;
    logic                   firstBeat;
    logic                   pktsFull;
    logic                   rejectBeat;
    logic                   wrEn;
    logic                   commit;
    logic                   pop;
    logic                   popLast;
    logic                   rdEn;

    // Occupancy is measured against rdPtr, so words already moved into the
    // egress register count as free. The extra pointer MSB separates full
    // from empty. A beat is the first of its packet when nothing has been
    // written speculatively since the last commit.
    assign beatIn     = in_TVALID & inReady_q;
    assign usedWords  = wrPtr_q - rdPtr_q;
    assign bufFull    = (usedWords == DEPTH_P);
    assign firstBeat  = (wrPtr_q == wrCommit_q);
    assign pktsFull   = (pktCount_q == MAXP_P);
    assign rejectBeat = bufFull | (firstBeat & pktsFull);
    assign wrEn       = beatIn & (wrState_q == ST_WR) & ~rejectBeat;
    assign commit     = wrEn & in_TLAST;

    // The egress register reloads whenever it is empty or being popped, and
    // only committed words (below wrCommit) are ever read.
    assign pop     = outValid_q & out_TREADY;
    assign popLast = pop & outLast_q;
    assign rdEn    = (rdPtr_q != wrCommit_q) & (~outValid_q | pop);
    assign rdWord  = mem[rdPtr_q[AW-1:0]];

    assign in_TREADY  = inReady_q;
    assign out_TVALID = outValid_q;
    assign out_TDATA  = outData_q;
    assign out_TKEEP  = outKeep_q;
    assign out_TLAST  = outLast_q;
    assign pkt_count  = pktCount_q;

    // The buffer never backpressures; ready rises on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inReady_q <= 1'b0;
        end else begin
            inReady_q <= 1'b1;
        end
    end

    // Packet storage holds data, keep and last together; it needs no reset
    // because only committed words are ever read back.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr_q[AW-1:0]] <= {in_TDATA, in_TKEEP, in_TLAST};
        end
    end

    // Write FSM: writes beats speculatively, commits on TLAST, and on a
    // rejected beat rewinds to the last commit and discards the rest of the
    // packet (staying in WR if the rejected beat was already the last one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrState_q  <= ST_WR;
            wrPtr_q    <= '0;
            wrCommit_q <= '0;
        end else if (beatIn) begin
            case (wrState_q)
                ST_WR: begin
                    if (rejectBeat) begin
                        wrPtr_q <= wrCommit_q;
                        if (!in_TLAST) begin
                            wrState_q <= ST_DROP;
                        end
                    end else begin
                        wrPtr_q <= wrPtr_q + PW'(1);
                        if (in_TLAST) begin
                            wrCommit_q <= wrPtr_q + PW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (in_TLAST) begin
                        wrState_q <= ST_WR;
                    end
                end
                default: begin
                    wrState_q <= ST_WR;
                end
            endcase
        end
    end

    // Read side: a one-cycle memory read straight into the egress register.
    // rdPtr advances at the read, so the word's space is reusable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outKeep_q  <= '0;
            outLast_q  <= 1'b0;
        end else if (rdEn) begin
            rdPtr_q    <= rdPtr_q + PW'(1);
            outValid_q <= 1'b1;
            outData_q  <= rdWord[MW-1 -: DATA_WIDTH];
            outKeep_q  <= rdWord[KW:1];
            outLast_q  <= rdWord[0];
        end else if (pop) begin
            outValid_q <= 1'b0;
        end
    end

    // Committed-packet count: up on an ingress commit, down when a final beat
    // leaves the egress, unchanged when both happen in the same cycle.
    always_comb begin
        pktCount_d = pktCount_q;
        if (commit && !popLast) begin
            pktCount_d = pktCount_q + CW'(1);
        end else if (!commit && popLast) begin
            pktCount_d = pktCount_q - CW'(1);
        end
    end

    // Register the committed-packet count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pktCount_q <= '0;
        end else begin
            pktCount_q <= pktCount_d;
        end
    end

`ifdef FWD_PKTBUF_DROP_CNT_EN
    logic        dropStart;
    logic [15:0] dropCnt_q;

    // A drop is counted once, on the beat that is rejected in WR; the rest of
    // that packet is discarded in DROP without counting again.
    assign dropStart    = beatIn & (wrState_q == ST_WR) & rejectBeat;
    assign pkts_dropped = dropCnt_q;

    // Saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCnt_q <= 16'h0000;
        end else if (dropStart && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'd1;
        end
    end
`else
    assign pkts_dropped = 16'h0000;
`endif

endmodule
